dmi_wishbone_master: RTL and testbench

//  Upstream neighbour of the DM Wishbone slave: converts DMI requests from the JTAG DTM
//  (addr/data/op) into single Wishbone classic cycles and returns DMI-style responses.
//  It is the only bus master driving the DM register file (dm.dmcontrol @ 0x10, etc.).

---
 rtl/dmi_wishbone_master.sv | 211 +++++++++++++++++++++
 tb/tb_dmi_wishbone_master.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_wishbone_master.sv
// ---------------------------------------------------------------------------
// dmi_wishbone_master
//
// Turns DMI requests coming from the JTAG DTM into single Wishbone classic
// cycles towards the Debug Module register file and hands back a DMI-style
// response (data + status). Only one request is in flight at a time.
//
// Handshakes: every valid/ready pair transfers on the rising clk_i edge where
// both are high. A producer keeps valid and its payload stable until it sees
// ready; rsp_valid_o/rsp_data_o/rsp_op_o are held until rsp_ready_i.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    request handshake (ready only while idle)
//   req_addr_i/data_i/op_i DMI address, write data, op (0 nop 1 rd 2 wr 3 rsvd)
//   rsp_valid_o/ready_i    response handshake
//   rsp_data_o, rsp_op_o   read data (or last read data), 0=ok 2=failed
//   addr_o, we_o, data_o   Wishbone address / write enable / write data
//   cyc_o, stb_o           Wishbone cycle and strobe (always identical)
//   data_i, ack_i          Wishbone read data and acknowledge
// ---------------------------------------------------------------------------
module dmi_wishbone_master #(
   parameter int unsigned ABITS          = 7,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [ABITS-1:0] req_addr_i,
   input  logic [31:0]      req_data_i,
   input  logic [1:0]       req_op_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_data_o,
   output logic [1:0]       rsp_op_o,
   output logic [31:0]      addr_o,
   output logic             we_o,
   output logic [31:0]      data_o,
   output logic             cyc_o,
   output logic             stb_o,
   input  logic [31:0]      data_i,
   input  logic             ack_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] RSP_OK   = 2'd0;
   localparam logic [1:0] RSP_FAIL = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUS     = 2'd1,
      S_RELEASE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic             we_q, we_d;
   logic             cyc_q, cyc_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [1:0]       rsp_op_q, rsp_op_d;

   logic req_accept;
   logic is_bus_op;
   logic timeout_hit;

   assign req_accept  = req_valid_i && (state_q == S_IDLE);
   assign is_bus_op   = (req_op_i == OP_READ) || (req_op_i == OP_WRITE);
   assign timeout_hit = (cnt_q == CNT_LAST);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         we_q        <= 1'b0;
         cyc_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_op_q    <= RSP_OK;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         we_q        <= we_d;
         cyc_q       <= cyc_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_op_q    <= rsp_op_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_accept) begin
               state_d = is_bus_op ? S_BUS : S_RESP;
            end
         end
         S_BUS: begin
            if (ack_i || timeout_hit) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // The slave holds ack until it sees the strobe drop; waiting for
            // it to clear keeps a stale ack from completing the next cycle.
            if (!ack_i) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output / datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      we_d        = we_q;
      cyc_d       = cyc_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_op_d    = rsp_op_q;
      case (state_q)
         S_IDLE: begin
            if (req_accept) begin
               if (is_bus_op) begin
                  addr_d = {{(32-ABITS){1'b0}}, req_addr_i};
                  data_d = req_data_i;
                  we_d   = (req_op_i == OP_WRITE);
                  cyc_d  = 1'b1;
                  cnt_d  = '0;
               end else begin
                  // nop answers at once with the previous read data
                  rsp_op_d    = (req_op_i == OP_NOP) ? RSP_OK : RSP_FAIL;
                  rsp_valid_d = 1'b1;
               end
            end
         end
         S_BUS: begin
            // An ack arriving on the last counted cycle still succeeds.
            if (ack_i) begin
               cyc_d    = 1'b0;
               we_d     = 1'b0;
               rsp_op_d = RSP_OK;
               if (!we_q) begin
                  rsp_data_d = data_i;
               end
            end else if (timeout_hit) begin
               cyc_d    = 1'b0;
               we_d     = 1'b0;
               rsp_op_d = RSP_FAIL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RELEASE: begin
            if (!ack_i) begin
               rsp_valid_d = 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_op_o    = rsp_op_q;
   assign addr_o      = addr_q;
   assign we_o        = we_q;
   assign data_o      = data_q;
   assign cyc_o       = cyc_q;
   assign stb_o       = cyc_q;

endmodule

// File: tb/tb_dmi_wishbone_master.sv
// Bench for dmi_wishbone_master: directed scenarios followed by random
// requests against a Wishbone slave model with programmable ack delay,
// ack linger and a "dead" (never acks) mode.
module tb_dmi_wishbone_master;

  localparam int ABITS = 7;
  localparam int TMO   = 16;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [ABITS-1:0] req_addr_i;
  logic [31:0]      req_data_i;
  logic [1:0]       req_op_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic [1:0]       rsp_op_o;
  logic [31:0]      addr_o;
  logic             we_o;
  logic [31:0]      data_o;
  logic             cyc_o;
  logic             stb_o;
  logic [31:0]      data_i;
  logic             ack_i;

  dmi_wishbone_master #(.ABITS(ABITS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_op_i(req_op_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_op_o(rsp_op_o),
    .addr_o(addr_o), .we_o(we_o), .data_o(data_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .data_i(data_i), .ack_i(ack_i)
  );

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    total++;
    bad++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // ---------------- Wishbone slave model ----------------
  int          ack_dly = 1;
  int          linger  = 0;
  bit          dead    = 1'b0;
  logic [31:0] seed_mem [0:127];
  logic [31:0] mem      [0:127];
  bit          mem_ready = 1'b0;
  int          stb_cnt;
  int          linger_cnt;

  assign ack_i  = !dead && ((stb_o && stb_cnt >= ack_dly) || (!stb_o && linger_cnt != 0));
  assign data_i = (addr_o < 32'h60) ? mem[addr_o[6:0]] : 32'h0;

  always @(posedge clk_i) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) mem[i] <= seed_mem[i];
      mem_ready <= 1'b1;
    end
    if (rst_i) begin
      stb_cnt    <= 0;
      linger_cnt <= 0;
    end else if (stb_o) begin
      if (ack_i && we_o && addr_o < 32'h60) mem[addr_o[6:0]] <= data_o;
      if (ack_i) linger_cnt <= linger;
      stb_cnt <= stb_cnt + 1;
    end else begin
      stb_cnt <= 0;
      if (linger_cnt != 0) linger_cnt <= linger_cnt - 1;
    end
  end

  // ---------------- response consumer ----------------
  bit hold_lo = 1'b0;
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      rsp_ready_i = hold_lo ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model + scoreboard queues ----------------
  // exp_q: {latency[7:0], rsp_op[1:0], rsp_data[31:0]}
  // bus_q: {cyc_len[7:0], we, addr[31:0], wdata[31:0]}
  logic [41:0] exp_q [$];
  logic [72:0] bus_q [$];
  logic [31:0] mdl_mem [0:127];
  logic [31:0] last_rd = 32'h0;

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [ABITS-1:0] a, input logic [31:0] wd);
    int          len, lat, guard;
    bit          tmo, mapped, accepted;
    logic [31:0] rd;
    logic [1:0]  rop;
    mapped = (a < 7'h60);
    tmo    = dead || (ack_dly >= TMO);
    if (op == 2'd1 || op == 2'd2) begin
      len = tmo ? TMO : ack_dly + 1;
      lat = len + 2 + (tmo ? 0 : linger);
      if (tmo) begin
        rd = last_rd; rop = 2'd2;
      end else begin
        rop = 2'd0;
        rd  = (op == 2'd1) ? (mapped ? mdl_mem[a] : 32'h0) : last_rd;
      end
    end else begin
      len = 0; lat = 1; rd = last_rd;
      rop = (op == 2'd3) ? 2'd2 : 2'd0;
    end
    req_op_i = op; req_addr_i = a; req_data_i = wd; req_valid_i = 1'b1;
    accepted = 1'b0;
    guard    = 0;
    while (!accepted && guard < 400) begin
      @(negedge clk_i);
      if (req_ready_o === 1'b1) accepted = 1'b1;
      guard++;
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    if (!accepted) begin
      fail_note("req_accept_timeout");
    end else begin
      if (op == 2'd2 && !tmo && mapped) mdl_mem[a] = wd;
      last_rd = rd;
      exp_q.push_back({8'(lat), rop, rd});
      if (len != 0) bus_q.push_back({8'(len), (op == 2'd2), {25'h0, a}, wd});
    end
  endtask

  task automatic set_slave(input int d, input int l, input bit dd);
    int guard = 0;
    bit idle  = 1'b0;
    while (!idle && guard < 400) begin
      @(negedge clk_i);
      if (req_ready_o === 1'b1) idle = 1'b1;
      guard++;
    end
    if (!idle) fail_note("idle_wait_timeout");
    @(posedge clk_i);
    #1;
    ack_dly = d; linger = l; dead = dd;
  endtask

  task automatic check_reset_values();
    @(negedge clk_i);
    chk("rst_cyc_o", cyc_o, 0);
    chk("rst_stb_o", stb_o, 0);
    chk("rst_we_o", we_o, 0);
    chk("rst_addr_o", addr_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_rsp_op", rsp_op_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- monitor ----------------
  bit          in_cyc = 0, sig_bad = 0, lat_on = 0, prev_hold = 0, prev_hs = 0;
  int          cyc_len = 0, lat_cnt = 0;
  logic [72:0] be;
  logic [41:0] ee;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete(); bus_q.delete();
      in_cyc = 0; lat_on = 0; prev_hold = 0; prev_hs = 0;
    end else begin
      // bus side
      if (cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1; cyc_len = 0; sig_bad = 0;
          total++;
          if (bus_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_cyc act=1 exp=0 t=%0t", $time);
          end
        end
        cyc_len++;
        if (bus_q.size() != 0) begin
          be = bus_q[0];
          if (stb_o !== 1'b1 || we_o !== be[64] || addr_o !== be[63:32] || data_o !== be[31:0])
            sig_bad = 1;
        end
      end else if (in_cyc) begin
        in_cyc = 0;
        chk("stb_low_after_cyc", stb_o, 0);
        if (bus_q.size() != 0) begin
          be = bus_q.pop_front();
          chk("cyc_len", cyc_len, be[72:65]);
          chk("bus_sigs_bad", sig_bad, 0);
        end
      end
      // response latency from accept edge
      if (lat_on) begin
        lat_cnt++;
        if (rsp_valid_o) begin
          lat_on = 0;
          if (exp_q.size() != 0) begin
            ee = exp_q[0];
            chk("rsp_latency", lat_cnt, ee[41:34]);
          end
        end
      end
      // response side
      if (prev_hold) chk("hold_valid", rsp_valid_o, 1);
      if (prev_hs) begin
        chk("ready_after_rsp", req_ready_o, 1);
        chk("valid_after_rsp", rsp_valid_o, 0);
      end
      if (rsp_valid_o) begin
        chk("req_ready_excl", req_ready_o, 0);
        if (exp_q.size() == 0) begin
          fail_note("unexpected_rsp");
        end else begin
          ee = exp_q[0];
          chk("rsp_data", rsp_data_o, ee[31:0]);
          chk("rsp_op", rsp_op_o, ee[33:32]);
          if (rsp_ready_i) void'(exp_q.pop_front());
        end
      end
      prev_hold = rsp_valid_o && !rsp_ready_i;
      prev_hs   = rsp_valid_o && rsp_ready_i;
      if (req_valid_i && req_ready_o) begin
        lat_on = 1; lat_cnt = 0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog_expired t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int r, d, l, g;
    bit dd;
    logic [1:0]  op;
    logic [6:0]  a;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_op_i = '0;
    for (int i = 0; i < 128; i++) begin
      seed_mem[i] = $urandom;
      mdl_mem[i]  = seed_mem[i];
    end
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_reset_values();

    // T1 write then read back
    set_slave(1, 0, 0);
    issue(2'd2, 7'h10, 32'h0000_002A);
    issue(2'd1, 7'h10, $urandom);
    // T2 unmapped read
    issue(2'd1, 7'h7F, $urandom);
    issue(2'd1, 7'h10, $urandom);
    // T4 nop / reserved
    issue(2'd0, 7'h10, $urandom);
    issue(2'd3, 7'h22, $urandom);
    // T3 timeouts: dead slave read and write, then read back untouched
    set_slave(1, 0, 1);
    issue(2'd1, 7'h10, $urandom);
    issue(2'd2, 7'h10, 32'hDEAD_BEEF);
    set_slave(1, 0, 0);
    issue(2'd1, 7'h10, $urandom);
    // ack on the last counted cycle, and one cycle too late
    set_slave(TMO - 1, 0, 0);
    issue(2'd1, 7'h05, $urandom);
    set_slave(TMO, 0, 0);
    issue(2'd1, 7'h05, $urandom);
    // lingering ack keeps the master in release
    set_slave(0, 2, 0);
    issue(2'd2, 7'h11, $urandom);
    issue(2'd1, 7'h11, $urandom);
    // T5 backpressure with a second request waiting
    set_slave(1, 0, 0);
    hold_lo = 1'b1;
    issue(2'd1, 7'h10, $urandom);
    fork
      issue(2'd0, 7'h00, $urandom);
      begin
        repeat (9) @(posedge clk_i);
        #1 hold_lo = 1'b0;
      end
    join
    // T6 reset in the middle of a bus cycle
    set_slave(1, 0, 1);
    issue(2'd1, 7'h10, $urandom);
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    last_rd = 32'h0;
    check_reset_values();
    set_slave(1, 0, 0);
    issue(2'd2, 7'h10, 32'h1234_5678);
    issue(2'd1, 7'h10, $urandom);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 19);
      d  = (r == 0) ? TMO - 1 : (r == 1) ? TMO : $urandom_range(0, 3);
      l  = $urandom_range(0, 2);
      dd = ($urandom_range(0, 19) == 0);
      set_slave(d, l, dd);
      r  = $urandom_range(0, 9);
      op = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
      a  = ($urandom_range(0, 3) == 0) ? 7'h10 : 7'($urandom_range(0, 127));
      issue(op, a, $urandom);
    end

    // drain
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk_i);
      g++;
    end
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_bus_q", bus_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
